note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter: TICK_DIV, 48000, clock cycles per WAIT unit (legal range 1..2^20).
REQ-002 SHALL have one clock and an asynchronous active-low reset, named as the codebase does: clk and rst_b.
REQ-003 SHALL have these ports:
- clk  in  1  sole clock; all logic on posedge.
- rst_b  in  1  asynchronous active-low reset.
- en  in  1  level; permits fetching new commands.
- flush  in  1  synchronous level; aborts activity.
- fifo_empty  in  1  command FIFO empty flag.
- fifo_data  in  32  command FIFO dout; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe.
- period  out  23  tone period to the square generator.
- gate  out  1  note sounding.
- note_on  out  1  one-cycle pulse to the envelope generator.
- note_off  out  1  one-cycle pulse to the envelope generator.
- bad_cmd  out  1  one-cycle pulse on a reserved opcode.
- busy  out  1  state != IDLE (combinational from the state register).

Function
REQ-004 Command word: bits [31:30] opcode; 00 NOTE (period = [22:0]); 01 OFF; 10 WAIT (count = [23:0]); 11 reserved.
REQ-005 States SHALL be IDLE, FETCH, LATCH, DECODE and WAIT.
REQ-006 IDLE: when en=1 and fifo_empty=0, next state is FETCH; otherwise stay in IDLE.
REQ-007 FETCH: fifo_rd_en=1 for exactly this one cycle; next state is LATCH. fifo_rd_en SHALL be 0 in every other state.
REQ-008 LATCH: register fifo_data into cmd; next state is DECODE.
REQ-009 DECODE, opcode NOTE with period != 0: period <= cmd[22:0], gate <= 1, note_on pulse; next state is IDLE.
REQ-010 NOTE with gate already 1 (retrigger): period updates, note_on pulses, gate stays 1, note_off stays 0.
REQ-011 NOTE with period = 0 SHALL be executed exactly as OFF.
REQ-012 DECODE, OFF: if gate=1, then gate <= 0 and note_off pulses; if gate=0, no pulse. period is held in both cases. Next state is IDLE.
REQ-013 DECODE, WAIT with count = 0: next state is IDLE.
REQ-014 DECODE, WAIT with count = N > 0: load a 24-bit unit counter with N and clear the tick counter; next state is WAIT.
REQ-015 WAIT state:
- The tick counter counts 0..TICK_DIV-1 and wraps.
- On each wrap the unit counter decrements.
- On the wrap where the unit counter is 1, next state is IDLE.
- Total WAIT residency is exactly N*TICK_DIV cycles.
REQ-016 DECODE, reserved opcode: bad_cmd pulses; no other output changes; next state is IDLE.
REQ-017 Outputs period, gate, note_on, note_off and bad_cmd SHALL be registered.
- If IDLE samples the fetch condition in cycle T, the DECODE effects are visible in cycle T+4.
- Back-to-back commands SHALL issue one per 4 cycles.
REQ-018 en deasserted SHALL only block the IDLE->FETCH transition. A command already in FETCH, LATCH, DECODE or WAIT completes.
REQ-019 flush=1 SHALL take priority over all transitions:
- Next state is IDLE.
- Unit and tick counters clear.
- If gate=1: gate <= 0 and note_off pulses in the same cycle.
- period is held.
REQ-020 flush during FETCH or LATCH: the popped word SHALL be discarded, not executed.
REQ-021 flush coincident with DECODE: the command SHALL be dropped. flush does not drain the FIFO.
REQ-022 note_on and note_off SHALL never be asserted in the same cycle.

Reset
REQ-023 rst_b=0 SHALL asynchronously force: state=IDLE, period=0, gate=0, note_on=0, note_off=0, bad_cmd=0, fifo_rd_en=0, all counters=0, cmd=0.
REQ-024 Reset asserted mid-WAIT or mid-FETCH SHALL abandon the command. No note_off pulse is generated by reset.
REQ-025 After rst_b rises, fetching SHALL begin on the first clk edge at which en=1 and fifo_empty=0.

Verification (TICK_DIV=4, FIFO model with 1-cycle read latency)
REQ-026 Push 0x0000_1234 with en=1 -> fifo_rd_en one cycle; period=0x001234, gate=1 and one note_on pulse 4 cycles after IDLE sees !empty.
REQ-027 Push NOTE 0x100, WAIT 3, OFF -> note_on, then exactly 12 WAIT cycles plus fetch overhead, then a single note_off; gate=0 and period=0x100 at the end.
REQ-028 Push NOTE 0x200 then NOTE 0x300 -> two note_on pulses 4 cycles apart, no note_off, gate stays 1, period=0x300.
REQ-029 NOTE 0x50 then WAIT 100; assert flush for 1 cycle mid-WAIT -> note_off pulse that cycle, gate=0, busy=0 next cycle, remaining FIFO words still fetched afterwards.
REQ-030 Push 0xC000_0000, then NOTE 0x0 while gate=0 -> one bad_cmd pulse, no note_on/note_off, all outputs otherwise unchanged.
REQ-031 Drop rst_b mid-WAIT while gate=1 -> gate=0 and period=0 immediately (asynchronously), no note_off; en=0 with a non-empty FIFO -> fifo_rd_en stays 0.

Source files
------------

// File: rtl/note_sequencer.sv
// Command-driven note sequencer: pops NOTE/OFF/WAIT words from a FIFO and drives
// the tone period, gate and envelope trigger pulses of a square-wave voice.
module note_sequencer #(
    parameter int TICK_DIV = 48000
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        en,
    input  logic        flush,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_rd_en,
    output logic [22:0] period,
    output logic        gate,
    output logic        note_on,
    output logic        note_off,
    output logic        bad_cmd,
    output logic        busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LATCH  = 3'd2;
    localparam logic [2:0] DECODE = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;

    localparam logic [1:0] OP_NOTE = 2'b00;
    localparam logic [1:0] OP_OFF  = 2'b01;
    localparam logic [1:0] OP_WAIT = 2'b10;

    // 21 bits covers the largest legal TICK_DIV of 2^20
    localparam int         TW        = 21;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [2:0]    state;
    logic [31:0]   cmd;
    logic [23:0]   units;
    logic [TW-1:0] tick;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd[29:24];

    assign fifo_rd_en = (state == FETCH);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            cmd      <= '0;
            units    <= '0;
            tick     <= '0;
            period   <= '0;
            gate     <= 1'b0;
            note_on  <= 1'b0;
            note_off <= 1'b0;
            bad_cmd  <= 1'b0;
        end else begin
            note_on  <= 1'b0;
            note_off <= 1'b0;
            bad_cmd  <= 1'b0;
            // flush overrides every transition; a fetched word is simply dropped
            if (flush) begin
                state <= IDLE;
                units <= '0;
                tick  <= '0;
                if (gate) begin
                    gate     <= 1'b0;
                    note_off <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (en && !fifo_empty) state <= FETCH;
                    end
                    FETCH: begin
                        state <= LATCH;
                    end
                    LATCH: begin
                        cmd   <= fifo_data;
                        state <= DECODE;
                    end
                    DECODE: begin
                        state <= IDLE;
                        case (cmd[31:30])
                            OP_NOTE: begin
                                if (cmd[22:0] != 23'd0) begin
                                    period  <= cmd[22:0];
                                    gate    <= 1'b1;
                                    note_on <= 1'b1;
                                end else if (gate) begin
                                    gate     <= 1'b0;
                                    note_off <= 1'b1;
                                end
                            end
                            OP_OFF: begin
                                if (gate) begin
                                    gate     <= 1'b0;
                                    note_off <= 1'b1;
                                end
                            end
                            OP_WAIT: begin
                                if (cmd[23:0] != 24'd0) begin
                                    units <= cmd[23:0];
                                    tick  <= '0;
                                    state <= WAIT;
                                end
                            end
                            default: begin
                                bad_cmd <= 1'b1;
                            end
                        endcase
                    end
                    WAIT: begin
                        // leave on the wrap that consumes the last unit
                        if (tick == TICK_LAST) begin
                            tick  <= '0;
                            units <= units - 24'd1;
                            if (units == 24'd1) state <= IDLE;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4 and a 1-cycle-latency FIFO model.
module tb_note_sequencer;

    logic        clk;
    logic        rst_b;
    logic        en;
    logic        flush;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rd_en;
    logic [22:0] period;
    logic        gate;
    logic        note_on;
    logic        note_off;
    logic        bad_cmd;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    int on_cnt, off_cnt, bad_cnt, rd_cnt, both_cnt;
    int first_on, first_off, first_bad, first_rd;
    logic busy_hist [0:127];

    note_sequencer #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .period     (period),
        .gate       (gate),
        .note_on    (note_on),
        .note_off   (note_off),
        .bad_cmd    (bad_cmd),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after the read strobe
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        fifo_mem[wr_ptr] = word;
        wr_ptr = wr_ptr + 1;
    endtask

    // Step n cycles, sampling at each falling edge (index 1 = first sample)
    task automatic observe(input int n);
        on_cnt = 0; off_cnt = 0; bad_cnt = 0; rd_cnt = 0;
        first_on = -1; first_off = -1; first_bad = -1; first_rd = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            busy_hist[i] = busy;
            if (note_on)  begin on_cnt++;  if (first_on  < 0) first_on  = i; end
            if (note_off) begin off_cnt++; if (first_off < 0) first_off = i; end
            if (bad_cmd)  begin bad_cnt++; if (first_bad < 0) first_bad = i; end
            if (fifo_rd_en) begin rd_cnt++; if (first_rd < 0) first_rd = i; end
            if (note_on && note_off) both_cnt++;
        end
    endtask

    initial begin
        both_cnt  = 0;
        fifo_data = '0;
        rst_b = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_period", 32'(period), 32'h0);
        checkOutput("rst_gate", 32'(gate), 32'h0);
        checkOutput("rst_note_on", 32'(note_on), 32'h0);
        checkOutput("rst_note_off", 32'(note_off), 32'h0);
        checkOutput("rst_bad_cmd", 32'(bad_cmd), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        rst_b = 1'b1;
        en    = 1'b1;
        @(negedge clk);

        // single NOTE: strobe next cycle, effects 4 cycles after IDLE sees data
        applyStimulus(32'h0000_1234);
        observe(5);
        checkOutput("n1_rd_first", 32'(first_rd), 32'd1);
        checkOutput("n1_rd_cnt", 32'(rd_cnt), 32'd1);
        checkOutput("n1_on_at", 32'(first_on), 32'd4);
        checkOutput("n1_on_cnt", 32'(on_cnt), 32'd1);
        checkOutput("n1_gate", 32'(gate), 32'd1);
        checkOutput("n1_period", 32'(period), 32'h1234);

        // two NOTEs back to back (retrigger)
        applyStimulus(32'h0000_0200);
        applyStimulus(32'h0000_0300);
        observe(9);
        checkOutput("rt_on_cnt", 32'(on_cnt), 32'd2);
        checkOutput("rt_on_first", 32'(first_on), 32'd4);
        checkOutput("rt_off_cnt", 32'(off_cnt), 32'd0);
        checkOutput("rt_gate", 32'(gate), 32'd1);
        checkOutput("rt_period", 32'(period), 32'h300);

        // NOTE, WAIT 3 (12 cycles), OFF
        applyStimulus(32'h0000_0100);
        applyStimulus(32'h8000_0003);
        applyStimulus(32'h4000_0000);
        observe(26);
        checkOutput("nw_on_at", 32'(first_on), 32'd4);
        checkOutput("nw_on_cnt", 32'(on_cnt), 32'd1);
        checkOutput("nw_busy_wait_end", 32'(busy_hist[19]), 32'd1);
        checkOutput("nw_busy_after_wait", 32'(busy_hist[20]), 32'd0);
        checkOutput("nw_off_at", 32'(first_off), 32'd24);
        checkOutput("nw_off_cnt", 32'(off_cnt), 32'd1);
        checkOutput("nw_rd_cnt", 32'(rd_cnt), 32'd3);
        checkOutput("nw_gate", 32'(gate), 32'd0);
        checkOutput("nw_period", 32'(period), 32'h100);

        // flush in the middle of WAIT 100, then the queued NOTE still runs
        applyStimulus(32'h0000_0050);
        applyStimulus(32'h8000_0064);
        applyStimulus(32'h0000_0060);
        observe(20);
        checkOutput("fw_on_cnt", 32'(on_cnt), 32'd1);
        checkOutput("fw_busy_in_wait", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("fw_note_off", 32'(note_off), 32'd1);
        checkOutput("fw_gate", 32'(gate), 32'd0);
        checkOutput("fw_busy", 32'(busy), 32'd0);
        checkOutput("fw_period_held", 32'(period), 32'h50);
        observe(4);
        checkOutput("fw_off_one_cycle", 32'(off_cnt), 32'd0);
        checkOutput("fw_next_rd", 32'(first_rd), 32'd1);
        checkOutput("fw_next_on", 32'(first_on), 32'd4);
        checkOutput("fw_next_period", 32'(period), 32'h60);

        applyStimulus(32'h4000_0000);
        observe(4);
        checkOutput("off_at", 32'(first_off), 32'd4);
        checkOutput("off_gate", 32'(gate), 32'd0);

        // flush while the word is being popped: word is discarded
        applyStimulus(32'h0000_0077);
        @(negedge clk);
        checkOutput("ff_rd_en", 32'(fifo_rd_en), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("ff_busy", 32'(busy), 32'd0);
        observe(8);
        checkOutput("ff_on_cnt", 32'(on_cnt), 32'd0);
        checkOutput("ff_rd_cnt", 32'(rd_cnt), 32'd0);
        checkOutput("ff_period", 32'(period), 32'h60);

        // reserved opcode, then NOTE 0 with gate low
        applyStimulus(32'hC000_0000);
        applyStimulus(32'h0000_0000);
        observe(9);
        checkOutput("bad_cnt", 32'(bad_cnt), 32'd1);
        checkOutput("bad_at", 32'(first_bad), 32'd4);
        checkOutput("bad_on_cnt", 32'(on_cnt), 32'd0);
        checkOutput("bad_off_cnt", 32'(off_cnt), 32'd0);
        checkOutput("bad_rd_cnt", 32'(rd_cnt), 32'd2);
        checkOutput("bad_gate", 32'(gate), 32'd0);
        checkOutput("bad_period", 32'(period), 32'h60);

        // asynchronous reset mid-WAIT with gate high, then en=0 blocks fetching
        applyStimulus(32'h0000_0090);
        applyStimulus(32'h8000_000A);
        applyStimulus(32'h0000_00A0);
        observe(10);
        checkOutput("rw_gate_before", 32'(gate), 32'd1);
        en = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        checkOutput("rw_async_gate", 32'(gate), 32'd0);
        checkOutput("rw_async_period", 32'(period), 32'h0);
        checkOutput("rw_async_busy", 32'(busy), 32'd0);
        checkOutput("rw_async_off", 32'(note_off), 32'd0);
        observe(2);
        checkOutput("rw_off_cnt", 32'(off_cnt), 32'd0);
        rst_b = 1'b1;
        observe(6);
        checkOutput("en0_rd_cnt", 32'(rd_cnt), 32'd0);
        checkOutput("en0_busy", 32'(busy), 32'd0);
        checkOutput("en0_off_cnt", 32'(off_cnt), 32'd0);

        en = 1'b1;
        observe(4);
        checkOutput("en1_rd_at", 32'(first_rd), 32'd1);
        checkOutput("en1_on_at", 32'(first_on), 32'd4);
        checkOutput("en1_period", 32'(period), 32'hA0);

        checkOutput("on_off_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
